// File: rtl/reset_hold_ctrl_pkg.sv
// Shared definitions for the reset-button hold controller: FSM encoding and
// the default width of the 2 kHz game counter it supervises.
package reset_hold_ctrl_pkg;

    localparam int CNT_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        HOLD    = 3'd2,
        FIRE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // The counter is held in measurement mode in every state except IDLE.
    function automatic logic counter_active(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/reset_hold_ctrl.sv
// Separates short and long (>=2 s) presses of the reset button using the
// external game counter, and captures free-running counts as dealer seeds.
module reset_hold_ctrl
    import reset_hold_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk_2K,
    input  logic             i_Rst_n,
    input  logic             i_ResetBtn,
    input  logic [WIDTH-1:0] i_Count,
    input  logic             i_TwoSec,
    input  logic             i_SeedReq,
    output logic             o_RstCounter,
    output logic             o_ActCounter,
    output logic             o_ShortPress,
    output logic             o_GameReset,
    output logic [WIDTH-1:0] o_Seed,
    output logic             o_SeedValid
);

    state_t state;
    logic   seed_pend;
    logic   short_p0;

    always_ff @(posedge clk_2K) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            seed_pend    <= 1'b0;
            short_p0     <= 1'b0;
            o_ShortPress <= 1'b0;
            o_Seed       <= '0;
            o_SeedValid  <= 1'b0;
        end else begin
            short_p0     <= 1'b0;
            o_ShortPress <= short_p0;
            o_SeedValid  <= 1'b0;

            case (state)
                IDLE:    if (i_ResetBtn) state <= CLEAR;
                CLEAR:   state <= HOLD;
                HOLD: begin
                    // The two-second flag wins over a release in the same cycle.
                    if (i_TwoSec) begin
                        state <= FIRE;
                    end else if (!i_ResetBtn) begin
                        state    <= IDLE;
                        short_p0 <= 1'b1;
                    end
                end
                FIRE:    state <= RELEASE;
                RELEASE: if (!i_ResetBtn) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Seed requests outside IDLE stay pending; repeats merge into one capture.
            if (state == IDLE && (seed_pend || i_SeedReq)) begin
                o_Seed      <= i_Count;
                o_SeedValid <= 1'b1;
                seed_pend   <= 1'b0;
            end else if (i_SeedReq) begin
                seed_pend <= 1'b1;
            end
        end
    end

    assign o_RstCounter = (state == CLEAR);
    assign o_ActCounter = counter_active(state);
    assign o_GameReset  = (state == FIRE);

endmodule

// File: tb/tb_reset_hold_ctrl.sv
// Scoreboard bench for reset_hold_ctrl with a behavioural model of the
// saturating 2 kHz counter wired to its clear/activate outputs.
module tb_reset_hold_ctrl;

    localparam int W = 12;

    logic         clk_2K = 1'b0;
    logic         i_Rst_n;
    logic         i_ResetBtn;
    logic [W-1:0] i_Count;
    logic         i_TwoSec;
    logic         i_SeedReq;
    logic         o_RstCounter;
    logic         o_ActCounter;
    logic         o_ShortPress;
    logic         o_GameReset;
    logic [W-1:0] o_Seed;
    logic         o_SeedValid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // kind bits: {game reset, short press, seed valid}
    typedef struct {
        logic [2:0]   kind;
        logic [W-1:0] seed;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    reset_hold_ctrl #(.WIDTH(W)) dut (
        .clk_2K      (clk_2K),
        .i_Rst_n     (i_Rst_n),
        .i_ResetBtn  (i_ResetBtn),
        .i_Count     (i_Count),
        .i_TwoSec    (i_TwoSec),
        .i_SeedReq   (i_SeedReq),
        .o_RstCounter(o_RstCounter),
        .o_ActCounter(o_ActCounter),
        .o_ShortPress(o_ShortPress),
        .o_GameReset (o_GameReset),
        .o_Seed      (o_Seed),
        .o_SeedValid (o_SeedValid)
    );

    always #5 clk_2K = ~clk_2K;

    always @(posedge clk_2K) cyc <= cyc + 1;

    // Counter model: clear wins, saturates while active, wraps while idle.
    always @(posedge clk_2K) begin
        if (!i_Rst_n || o_RstCounter)
            i_Count <= '0;
        else if (o_ActCounter) begin
            if (i_Count != {W{1'b1}}) i_Count <= i_Count + 1'b1;
        end else
            i_Count <= i_Count + 1'b1;
    end
    assign i_TwoSec = (i_Count == {W{1'b1}});

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2K);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [W-1:0] seed, input int at);
        exp_t e;
        e.kind = kind;
        e.seed = seed;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse on the event outputs must match the queue head.
    initial begin
        logic [2:0] obs;
        exp_t e;
        forever begin
            @(negedge clk_2K);
            obs = {o_GameReset, o_ShortPress, o_SeedValid};
            if (obs != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got=%b want=none cyc=%0d", obs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs != e.kind || cyc != e.cyc || (e.kind[0] && o_Seed != e.seed)) begin
                        errors++;
                        $display("FAIL pulse got kind=%b cyc=%0d seed=%0d want kind=%b cyc=%0d seed=%0d",
                                 obs, cyc, o_Seed, e.kind, e.cyc, e.seed);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        bit found;

        i_Rst_n    = 1'b0;
        i_ResetBtn = 1'b0;
        i_SeedReq  = 1'b0;
        tick(3);
        chk("rst_RstCounter", o_RstCounter, 0);
        chk("rst_ActCounter", o_ActCounter, 0);
        chk("rst_ShortPress", o_ShortPress, 0);
        chk("rst_GameReset",  o_GameReset,  0);
        chk("rst_Seed",       o_Seed,       0);
        chk("rst_SeedValid",  o_SeedValid,  0);
        i_Rst_n = 1'b1;

        // Seed request in IDLE at count 37.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (i_Count == 37) found = 1;
            else tick(1);
        end
        chk("wait_count37", found, 1);
        i_SeedReq = 1'b1;
        push(3'b001, 12'd37, cyc + 1);
        tick(1);
        i_SeedReq = 1'b0;
        chk("seed37", o_Seed, 37);
        tick(2);

        // Long press held 5000 cycles.
        i_ResetBtn = 1'b1;
        k = cyc + 1;
        push(3'b100, '0, k + 4097);
        tick(1);
        chk("long_clear_rst", o_RstCounter, 1);
        chk("long_clear_act", o_ActCounter, 1);
        tick(1);
        chk("long_hold_rst", o_RstCounter, 0);
        chk("long_hold_act", o_ActCounter, 1);
        tick(4998);
        chk("long_release_act", o_ActCounter, 1);
        i_ResetBtn = 1'b0;
        tick(1);
        chk("long_idle_act", o_ActCounter, 0);
        tick(2);

        // Short press of 100 cycles.
        i_ResetBtn = 1'b1;
        k = cyc + 1;
        tick(100);
        chk("short_hold_act", o_ActCounter, 1);
        i_ResetBtn = 1'b0;
        r = cyc + 1;
        push(3'b010, '0, r + 1);
        tick(1);
        chk("short_idle_act", o_ActCounter, 0);
        tick(3);

        // Release in the same cycle the two-second flag rises.
        i_ResetBtn = 1'b1;
        k = cyc + 1;
        push(3'b100, '0, k + 4097);
        tick(2);
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (i_TwoSec) found = 1;
            else tick(1);
        end
        chk("wait_twosec", found, 1);
        chk("twosec_cycle", cyc, k + 4096);
        i_ResetBtn = 1'b0;
        tick(4);
        chk("race_idle_act", o_ActCounter, 0);

        // Three seed requests during HOLD merge into one capture after release.
        i_ResetBtn = 1'b1;
        k = cyc + 1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            i_SeedReq = 1'b1;
            tick(1);
            i_SeedReq = 1'b0;
            tick(10);
        end
        tick((k + 200) - cyc);
        i_ResetBtn = 1'b0;
        push(3'b011, 12'd200, k + 202);
        tick(4);
        chk("merged_seed", o_Seed, 200);

        // Reset at hold cycle 2000 with a seed request pending.
        i_ResetBtn = 1'b1;
        k = cyc + 1;
        tick(1000);
        i_SeedReq = 1'b1;
        tick(1);
        i_SeedReq = 1'b0;
        tick((k + 2000) - cyc);
        i_Rst_n = 1'b0;
        tick(1);
        chk("midrst_act",   o_ActCounter, 0);
        chk("midrst_rst",   o_RstCounter, 0);
        chk("midrst_game",  o_GameReset,  0);
        chk("midrst_short", o_ShortPress, 0);
        chk("midrst_seed",  o_Seed,       0);
        tick(1);
        i_Rst_n = 1'b1;
        tick(1);
        chk("reenter_clear", o_RstCounter, 1);
        i_ResetBtn = 1'b0;
        push(3'b010, '0, cyc + 3);
        tick(1);
        chk("clear_to_hold_act", o_ActCounter, 1);
        tick(6);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got=%0d want=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
